// File: rtl/down_counter_sync.sv
// Free-running down counter with terminal-count decode, registered wrap pulse
// and a saturating tally of wraps since reset.
module down_counter_sync #(
  parameter int          WIDTH    = 4,
  parameter int unsigned HIGH_VAL = (2**WIDTH) - 1,
  parameter int unsigned LOW_VAL  = 0,
  parameter int          WCNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              wrap,
  output logic [WCNT_W-1:0] wrap_cnt
);

  localparam logic [WIDTH-1:0] HIGH_Q = WIDTH'(HIGH_VAL);
  localparam logic [WIDTH-1:0] LOW_Q  = WIDTH'(LOW_VAL);

  // Tally sticks at all-ones instead of rolling over.
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    return (&v) ? v : v + WCNT_W'(1);
  endfunction

  logic at_low;

  always_comb begin
    at_low = (q == LOW_Q);
    tc     = at_low;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= HIGH_Q;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
    end else if (at_low) begin
      q        <= HIGH_Q;
      wrap     <= 1'b1;
      wrap_cnt <= sat_inc(wrap_cnt);
    end else begin
      q        <= q - WIDTH'(1);
      wrap     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_down_counter_sync.sv
// Directed bench for down_counter_sync: default instance plus a narrow-tally
// instance and a reduced-range instance sharing one clock and reset.
module tb_down_counter_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] q;
  logic       tc, wrap;
  logic [7:0] wrap_cnt;
  logic [3:0] qs;
  logic       tcs, wraps;
  logic [1:0] wcs;
  logic [2:0] qp;
  logic       tcp, wrapp;
  logic [7:0] wcp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  down_counter_sync dut (
    .clk(clk), .rst(rst), .q(q), .tc(tc), .wrap(wrap), .wrap_cnt(wrap_cnt)
  );

  down_counter_sync #(.WCNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .q(qs), .tc(tcs), .wrap(wraps), .wrap_cnt(wcs)
  );

  down_counter_sync #(.WIDTH(3), .HIGH_VAL(5), .LOW_VAL(2)) dut_p (
    .clk(clk), .rst(rst), .q(qp), .tc(tcp), .wrap(wrapp), .wrap_cnt(wcp)
  );

  typedef struct {
    logic       rst;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];

  function automatic void add(logic r, logic [3:0] eq, logic et, logic ew, logic [7:0] ec);
    vec_t v;
    v.rst = r; v.q = eq; v.tc = et; v.wrap = ew; v.cnt = ec;
    vt.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [2:0] pq [8];
    logic       pw [8];
    // reset held across one edge, then a full period plus wrap and one more step
    add(1'b0, 4'd15, 1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd14, 1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd13, 1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd12, 1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd11, 1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd10, 1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd9,  1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd8,  1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd7,  1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd6,  1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd5,  1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd4,  1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd3,  1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd2,  1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd1,  1'b0, 1'b0, 8'd0);
    add(1'b1, 4'd0,  1'b1, 1'b0, 8'd0);
    add(1'b1, 4'd15, 1'b0, 1'b1, 8'd1);
    add(1'b1, 4'd14, 1'b0, 1'b0, 8'd1);

    pq = '{3'd4, 3'd3, 3'd2, 3'd5, 3'd4, 3'd3, 3'd2, 3'd5};
    pw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    // T1: asynchronous reset, checked before any clock edge
    #1 rst = 1'b0;
    #1;
    chk("rst_q",    q,        15);
    chk("rst_tc",   tc,       0);
    chk("rst_wrap", wrap,     0);
    chk("rst_cnt",  wrap_cnt, 0);
    chk("rst_qp",   qp,       5);

    // T2/T3: table-driven period and first wrap
    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst;
      step(1);
      chk($sformatf("vec%0d_q", i),    q,        vt[i].q);
      chk($sformatf("vec%0d_tc", i),   tc,       vt[i].tc);
      chk($sformatf("vec%0d_wrap", i), wrap,     vt[i].wrap);
      chk($sformatf("vec%0d_cnt", i),  wrap_cnt, vt[i].cnt);
    end

    // continue down to 0 without another wrap, then the second wrap
    step(14);
    chk("run_q0",    q,        0);
    chk("run_tc",    tc,       1);
    chk("run_cnt1",  wrap_cnt, 1);
    step(1);
    chk("wrap2_q",   q,        15);
    chk("wrap2_w",   wrap,     1);
    chk("wrap2_cnt", wrap_cnt, 2);

    // T4: async reset between edges at q=7
    step(8);
    chk("pre_rst_q", q, 7);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_q",    q,        15);
    chk("mid_rst_cnt",  wrap_cnt, 0);
    chk("mid_rst_wrap", wrap,     0);
    chk("mid_rst_qp",   qp,       5);
    chk("mid_rst_wcs",  wcs,      0);
    step(1);
    chk("held_q", q, 15);
    rst = 1'b1;

    // T6: reduced range 5..2, period 4
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("p%0d_q", i),    qp,    pq[i]);
      chk($sformatf("p%0d_tc", i),   tcp,   (pq[i] == 3'd2));
      chk($sformatf("p%0d_wrap", i), wrapp, pw[i]);
    end
    chk("p_cnt", wcp, 2);
    chk("p_dflt_q", q, 7);

    // T5: 2-bit tally saturates at 3
    step(40);
    chk("sat48_wcs", wcs,      3);
    chk("sat48_cnt", wrap_cnt, 3);
    chk("sat48_w",   wrap,     1);
    step(32);
    chk("sat80_wcs", wcs,      3);
    chk("sat80_ws",  wraps,    1);
    chk("sat80_cnt", wrap_cnt, 5);
    chk("sat80_qs",  qs,       15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
